// File: rtl/tile_sequencer.sv
// Tile job sequencer: loads A/B blocks from memory into the register file, hands the RF to
// the PU for each partial product, then stores the C block back to memory.
module tile_sequencer #(
   parameter int SIZE           = 4,
   parameter int CELL_WIDTH     = 8,
   parameter int INDEX_WIDTH    = 4,
   parameter int MEM_ADDR_WIDTH = 16,
   parameter int A_BASE         = 0,
   parameter int B_BASE         = 256,
   parameter int C_BASE         = 512,
   localparam int W             = SIZE * CELL_WIDTH,
   localparam int AW            = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                      in_clk,
   input  logic                      in_reset,
   input  logic                      in_index_ready,
   input  logic [INDEX_WIDTH-1:0]    in_row_index,
   input  logic [INDEX_WIDTH-1:0]    in_col_index,
   input  logic [INDEX_WIDTH-1:0]    in_mu,
   output logic                      out_index_ack,
   output logic                      out_result_ready,
   output logic                      out_request,
   input  logic                      in_grant,
   output logic                      out_mem_read_en,
   output logic                      out_mem_write_en,
   output logic [MEM_ADDR_WIDTH-1:0] out_mem_address,
   output logic [W-1:0]              out_mem_data,
   input  logic [W-1:0]              in_mem_data,
   output logic [AW-1:0]             out_rf_address,
   output logic [1:0]                out_rf_matrix,
   output logic                      out_rf_read_en,
   output logic                      out_rf_write_en,
   output logic [W-1:0]              out_rf_data,
   input  logic [W-1:0]              in_rf_data,
   output logic                      out_pu_start,
   output logic                      out_pu_clear,
   input  logic                      in_pu_done,
   output logic                      out_pu_ack,
   output logic                      out_pu_owns_rf
);

   // state   | meaning
   // IDLE    | waiting for a job request
   // LOAD_A  | reading A(i,k) rows into RF matrix A
   // LOAD_B  | reading B(k,j) rows into RF matrix B
   // COMPUTE | PU owns the RF, bus released, waiting for in_pu_done
   // STORE_C | reading RF matrix C rows and writing them to memory
   // DONE    | job finished, result pulse follows
   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, STORE_C, DONE} state_t;

   localparam int CW = $clog2(SIZE + 1);
   localparam logic [CW-1:0] ROWS = CW'(SIZE);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   state_t                  state;
   logic [INDEX_WIDTH-1:0]  row_i, col_j, mu_q, k;
   logic [CW-1:0]           r, wcnt;
   logic                    pend, held;
   logic [AW-1:0]           pend_row;
   logic [W-1:0]            hold_data;

   logic                    loading, storing, issue, wr_fire;
   logic [AW-1:0]           r_row;
   logic [INDEX_WIDTH:0]    k_inc;
   logic [MEM_ADDR_WIDTH-1:0] a_addr, b_addr, c_addr;

   function automatic logic [MEM_ADDR_WIDTH-1:0] blk_addr(
      input logic [MEM_ADDR_WIDTH-1:0] base,
      input logic [INDEX_WIDTH-1:0]    a,
      input logic [INDEX_WIDTH-1:0]    b,
      input logic [INDEX_WIDTH-1:0]    m,
      input logic [AW-1:0]             row
   );
      logic [MEM_ADDR_WIDTH-1:0] blk;
      blk = MEM_ADDR_WIDTH'(a) * MEM_ADDR_WIDTH'(m) + MEM_ADDR_WIDTH'(b);
      return base + blk * MEM_ADDR_WIDTH'(SIZE) + MEM_ADDR_WIDTH'(row);
   endfunction

   assign loading  = (state == LOAD_A) || (state == LOAD_B);
   assign storing  = (state == STORE_C);
   assign issue    = (loading || storing) && in_grant && (r < ROWS);
   assign wr_fire  = storing && pend && in_grant;
   assign r_row    = AW'(r);
   assign k_inc    = {1'b0, k} + {{INDEX_WIDTH{1'b0}}, 1'b1};
   assign a_addr   = blk_addr(MEM_ADDR_WIDTH'(A_BASE), row_i, k, mu_q, r_row);
   assign b_addr   = blk_addr(MEM_ADDR_WIDTH'(B_BASE), k, col_j, mu_q, r_row);
   assign c_addr   = blk_addr(MEM_ADDR_WIDTH'(C_BASE), row_i, col_j, mu_q, pend_row);

   assign out_request    = loading || storing;
   assign out_pu_owns_rf = (state == COMPUTE);

   // Strobes follow in_grant combinationally so no memory access ever lands on a lost grant.
   always_comb begin
      out_mem_read_en  = 1'b0;
      out_mem_write_en = 1'b0;
      out_mem_address  = '0;
      out_mem_data     = '0;
      out_rf_address   = '0;
      out_rf_matrix    = 2'b00;
      out_rf_read_en   = 1'b0;
      out_rf_write_en  = 1'b0;
      out_rf_data      = '0;
      if (loading) begin
         if (issue) begin
            out_mem_read_en = 1'b1;
            out_mem_address = (state == LOAD_A) ? a_addr : b_addr;
         end
         if (pend) begin
            out_rf_write_en = 1'b1;
            out_rf_address  = pend_row;
            out_rf_matrix   = (state == LOAD_B) ? 2'b01 : 2'b00;
            out_rf_data     = in_mem_data;
         end
      end else if (storing) begin
         if (issue) begin
            out_rf_read_en = 1'b1;
            out_rf_address = r_row;
            out_rf_matrix  = 2'b10;
         end
         if (wr_fire) begin
            out_mem_write_en = 1'b1;
            out_mem_address  = c_addr;
            out_mem_data     = held ? hold_data : in_rf_data;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state <= IDLE;
         row_i <= '0; col_j <= '0; mu_q <= '0; k <= '0;
         r <= '0; wcnt <= '0; pend <= 1'b0; pend_row <= '0;
         held <= 1'b0; hold_data <= '0;
         out_index_ack <= 1'b0; out_result_ready <= 1'b0;
         out_pu_start <= 1'b0; out_pu_clear <= 1'b0; out_pu_ack <= 1'b0;
      end else begin
         out_index_ack    <= 1'b0;
         out_result_ready <= 1'b0;
         out_pu_start     <= 1'b0;
         out_pu_clear     <= 1'b0;
         out_pu_ack       <= 1'b0;
         case (state)
            IDLE: begin
               if (in_index_ready) begin
                  row_i <= in_row_index;
                  col_j <= in_col_index;
                  mu_q  <= in_mu;
                  k     <= '0;
                  r     <= '0;
                  wcnt  <= '0;
                  pend  <= 1'b0;
                  held  <= 1'b0;
                  out_index_ack <= 1'b1;
                  state <= (in_mu == '0) ? DONE : LOAD_A;
               end
            end
            LOAD_A, LOAD_B: begin
               if (issue) begin
                  r        <= r + CW'(1);
                  pend     <= 1'b1;
                  pend_row <= r_row;
               end else begin
                  pend <= 1'b0;
               end
               if (pend) begin
                  wcnt <= wcnt + CW'(1);
                  if (wcnt == LAST) begin
                     r    <= '0;
                     wcnt <= '0;
                     if (state == LOAD_A) begin
                        state <= LOAD_B;
                     end else begin
                        state        <= COMPUTE;
                        out_pu_start <= 1'b1;
                        out_pu_clear <= (k == '0);
                     end
                  end
               end
            end
            COMPUTE: begin
               if (in_pu_done) begin
                  out_pu_ack <= 1'b1;
                  r    <= '0;
                  wcnt <= '0;
                  if (k_inc < {1'b0, mu_q}) begin
                     k     <= k_inc[INDEX_WIDTH-1:0];
                     state <= LOAD_A;
                  end else begin
                     state <= STORE_C;
                  end
               end
            end
            STORE_C: begin
               if (issue) begin
                  r        <= r + CW'(1);
                  pend     <= 1'b1;
                  pend_row <= r_row;
               end else if (wr_fire) begin
                  pend <= 1'b0;
               end
               // RF read data is only valid for one cycle, so park it while the grant is gone.
               if (wr_fire) begin
                  held <= 1'b0;
                  wcnt <= wcnt + CW'(1);
                  if (wcnt == LAST) state <= DONE;
               end else if (pend) begin
                  held <= 1'b1;
                  if (!held) hold_data <= in_rf_data;
               end
            end
            DONE: begin
               out_result_ready <= 1'b1;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
